dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-port data memory. It lets the core load/store path (port 0) and a debug/loader port (port 1) share one memory, one access per cycle. It blocks out-of-range writes and returns a registered, tagged response one cycle after each accepted access. It sits between the datapath's memory stage and the data memory's `WE`/`A`/`WD`/`RD` pins.

## Interface
Parameters:
- `DEPTH`, 1024: memory depth in 32-bit words; legal word addresses are 0..DEPTH-1.
- `MAX_WAIT`, 8: fixed-priority mode only; cycles port 1 may be refused before it is forced through.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `p0_req`, `p1_req`  in  1  access request; must hold with fields stable until granted.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read.
- `p0_addr`, `p1_addr`  in  32  word address.
- `p0_wdata`, `p1_wdata`  in  32  write data.
- `p0_gnt`, `p1_gnt`  out  1  combinational grant; an access is accepted when `req & gnt` at a rising edge.
- `p0_rvalid`, `p1_rvalid`  out  1  registered one-cycle response strobe.
- `p0_rdata`, `p1_rdata`  out  32  registered read data; 0 for writes and errors.
- `p0_err`, `p1_err`  out  1  registered, valid with `rvalid`: address was out of range.
- `mem_we`  out  1  to data memory `WE`.
- `mem_a`  out  32  to data memory `A`.
- `mem_wd`  out  32  to data memory `WD`.
- `mem_rd`  in  32  from data memory `RD` (combinational read).

## Operation
- At most one grant per cycle. `p0_gnt & p1_gnt` is never 1.
- Default arbitration is fixed priority, port 0 over port 1, with starvation relief:
  - Counter `wait1` (width `$clog2(MAX_WAIT+1)`) increments, saturating at `MAX_WAIT`, each cycle `p1_req & !p1_gnt`.
  - `wait1` clears when port 1 is accepted or `p1_req` is low.
  - While `wait1 == MAX_WAIT`, port 1 wins over port 0.
- When a port is granted, `mem_a`, `mem_wd` and `mem_we` are driven from that port's fields.
- `mem_we = gnt & we & in_range`, where `in_range = (addr < DEPTH)` as an unsigned 32-bit compare.
- With no grant, `mem_we`, `mem_a` and `mem_wd` are 0.
- Every accepted access, read or write, produces exactly one response on the granting port in the next cycle:
  - `rvalid` = 1.
  - `err` = `!in_range`.
  - `rdata` = `mem_rd` sampled at the accept edge for an in-range read, else 0.
- If a port is not accepted this cycle, its `rvalid`, `rdata` and `err` go to 0 next cycle. `rdata` does not hold stale values.
- Out-of-range accesses still complete the handshake. The write is suppressed and nothing is written.

## Timing
- Grant latency is 0 cycles: `gnt` is combinational on `req` and arbitration state in the same cycle.
- A write commits at the accept edge.
- Read and write response latency is exactly 1 cycle after accept.
- Back-to-back accesses from the same port are allowed every cycle. Responses then stream with `rvalid` held high.
- Read-after-write to the same address on consecutive accepts returns the new data, because the memory writes at edge N and is read combinationally in cycle N+1.
- Reset, while `rst` = 1:
  - `p0_gnt`, `p1_gnt` and `mem_we` are forced to 0.
  - At the next edge, all `rvalid`, `rdata` and `err` become 0, `wait1` = 0, and the round-robin pointer = "port 1 last".
- Reset mid-operation: a response due in the cycle after reset asserts is dropped, not delayed.
- When both requests rise in the same cycle, the decision follows the current priority state. The loser keeps `gnt` = 0 and must keep requesting.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit `last` register records the most recently accepted port.
  - On contention, the other port wins. With a single requester, that requester is granted.
  - `wait1` and `MAX_WAIT` are unused and not instantiated.
- Not defined: fixed priority with the `wait1` starvation relief above.
- Macro selection changes nothing else: responses, error handling and reset behaviour are identical in both modes.

## Test plan
- Port 0 writes 0xDEADBEEF to addr 5, then port 0 reads addr 5.
  - Required: `mem_we` = 1 for one cycle with `mem_a` = 5.
  - Required: `p0_rvalid` pulses after each accept, write ack with `rdata` 0, then `p0_rdata` = 0xDEADBEEF.
- Both ports request reads every cycle for 20 cycles, fixed-priority build, `MAX_WAIT` = 8.
  - Required: port 0 is granted for 8 cycles, then port 1 for 1 cycle, repeating.
  - Required: `p0_gnt & p1_gnt` is never 1.
- Same stimulus in a `DMEM_ARB_RR_EN` build.
  - Required: grants alternate p0, p1, p0, … starting with p0 after reset.
- Port 1 writes 0x1234 to addr 1024 (= `DEPTH`).
  - Required: accepted, `mem_we` stays 0, `p1_rvalid` = 1 and `p1_err` = 1 next cycle.
  - Required: a later read of addr 0 and addr 1023 shows no change.
- Port 0 read accepted at edge N, `rst` = 1 sampled at edge N+1.
  - Required: `p0_rvalid` = 0 after edge N+1, and every output is 0 with both `gnt` low while `rst` stays high.
- Port 1 requests alone while port 0 is idle.
  - Required: `p1_gnt` = 1 in the same cycle in both builds, and `wait1` stays 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer in front of the single-port data memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority with starvation relief.
module dmem_arbiter #(
    parameter int DEPTH    = 1024,
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p0_gnt,
    output logic        p1_gnt,
    output logic        p0_rvalid,
    output logic        p1_rvalid,
    output logic [31:0] p0_rdata,
    output logic [31:0] p1_rdata,
    output logic        p0_err,
    output logic        p1_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    logic        w_p0_in;
    logic        w_p1_in;
    logic        w_p1_wins;
    logic        r_p0_rvalid, r_p1_rvalid;
    logic        r_p0_err, r_p1_err;
    logic [31:0] r_p0_rdata, r_p1_rdata;

    assign w_p0_in = (p0_addr < 32'(DEPTH));
    assign w_p1_in = (p1_addr < 32'(DEPTH));

`ifdef DMEM_ARB_RR_EN
    // r_last: 0 = port 0 accepted most recently, 1 = port 1.
    logic r_last;

    assign w_p1_wins = !r_last;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_last <= 1'b1;
        end else if (p0_gnt) begin
            r_last <= 1'b0;
        end else if (p1_gnt) begin
            r_last <= 1'b1;
        end
    end
`else
    localparam int              WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_wait1;

    assign w_p1_wins = (r_wait1 == WAIT_SAT);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst || !p1_req || p1_gnt) begin
            r_wait1 <= '0;
        end else if (r_wait1 != WAIT_SAT) begin
            r_wait1 <= r_wait1 + 1'b1;
        end
    end
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst) begin
            p1_gnt = p1_req & (!p0_req | w_p1_wins);
            p0_gnt = p0_req & !p1_gnt;
        end
    end

    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        if (p0_gnt) begin
            mem_we = p0_we & w_p0_in;
            mem_a  = p0_addr;
            mem_wd = p0_wdata;
        end else if (p1_gnt) begin
            mem_we = p1_we & w_p1_in;
            mem_a  = p1_addr;
            mem_wd = p1_wdata;
        end
    end

    // Responses are rebuilt every cycle, so an idle port drops back to all-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p0_rvalid <= 1'b0;
            r_p0_err    <= 1'b0;
            r_p0_rdata  <= '0;
            r_p1_rvalid <= 1'b0;
            r_p1_err    <= 1'b0;
            r_p1_rdata  <= '0;
        end else begin
            r_p0_rvalid <= p0_gnt;
            r_p0_err    <= p0_gnt & !w_p0_in;
            r_p0_rdata  <= (p0_gnt && !p0_we && w_p0_in) ? mem_rd : 32'h0;
            r_p1_rvalid <= p1_gnt;
            r_p1_err    <= p1_gnt & !w_p1_in;
            r_p1_rdata  <= (p1_gnt && !p1_we && w_p1_in) ? mem_rd : 32'h0;
        end
    end

    assign p0_rvalid = r_p0_rvalid;
    assign p0_err    = r_p0_err;
    assign p0_rdata  = r_p0_rdata;
    assign p1_rvalid = r_p1_rvalid;
    assign p1_err    = r_p1_err;
    assign p1_rdata  = r_p1_rdata;

endmodule
